// File: rtl/wave_dac_serializer_if.sv
// Generator-side handshake and DAC serial pins of the waveform output stage.
interface wave_dac_serializer_if;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  gain;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_mosi;
  logic        busy;
  logic        frame_done;

  // Driver of samples and observer of the DAC pins
  modport master (
    output sample,
    output sample_valid,
    output gain,
    input  sample_ready,
    input  dac_cs_n,
    input  dac_sclk,
    input  dac_mosi,
    input  busy,
    input  frame_done
  );

  // The serializer itself
  modport slave (
    input  sample,
    input  sample_valid,
    input  gain,
    output sample_ready,
    output dac_cs_n,
    output dac_sclk,
    output dac_mosi,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/wave_dac_serializer.sv
// Scales 16-bit waveform samples by (gain+1)/256 and shifts them MSB first to a
// 16-bit SPI DAC. Every output is a register; the next-state logic computes the
// value each output must hold in the state being entered.
module wave_dac_serializer #(
  parameter int unsigned CLK_DIV = 4
) (
  input logic                  clk,
  input logic                  reset,
  wave_dac_serializer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StScale, StSetup, StShift, StHold} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic        phase_q, phase_d;  // 0: sclk high half, 1: sclk low half
  logic [15:0] sample_q, sample_d;
  logic [7:0]  gain_q, gain_d;
  logic [15:0] scaled_q, scaled_d;
  logic        ready_q, ready_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [24:0] product;

  // Full 25-bit product; gain+1 spans 1..256 so it needs 9 bits
  assign product = 25'(sample_q) * 25'({1'b0, gain_q} + 9'd1);

  // Next state, counters and the output values for the state being entered
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    sample_d = sample_q;
    gain_d   = gain_q;
    scaled_d = scaled_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        div_d  = '0;
        bit_d  = '0;
        if (bus.sample_valid && ready_q) begin
          sample_d = bus.sample;
          gain_d   = bus.gain;
          state_d  = StScale;
        end
      end
      StScale: begin
        scaled_d = product[23:8];
        cs_n_d   = 1'b0;
        sclk_d   = 1'b0;
        mosi_d   = product[23];
        div_d    = '0;
        state_d  = StSetup;
      end
      StSetup: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          bit_d   = 4'd15;
          phase_d = 1'b0;
          sclk_d  = 1'b1;
          state_d = StShift;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StShift: begin
        if (div_q != DivLast) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!phase_q) begin
            // Falling sclk: present the next bit, or keep bit 0 after the last one
            phase_d = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = (bit_q != 4'd0) ? scaled_q[bit_q - 4'd1] : scaled_q[0];
          end else if (bit_q == 4'd0) begin
            phase_d = 1'b0;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StHold;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q - 4'd1;
            sclk_d  = 1'b1;
          end
        end
      end
      StHold: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (div_q == DivLast) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      sample_q <= '0;
      gain_q   <= '0;
      scaled_q <= '0;
      ready_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      gain_q   <= gain_d;
      scaled_q <= scaled_d;
      ready_q  <= ready_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.sample_ready = ready_q;
  assign bus.dac_cs_n     = cs_n_q;
  assign bus.dac_sclk     = sclk_q;
  assign bus.dac_mosi     = mosi_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = done_q;

endmodule

// File: doc/wave_dac_serializer.md
# wave_dac_serializer

Downstream output stage of the DDS waveform path. It takes the 16-bit unsigned samples produced by the waveform generators (triangular, sine, etc.) and applies an 8-bit amplitude gain. It then shifts each scaled sample, MSB first, to an external 16-bit SPI DAC with chip-select framing. Sample rate is set by the serial frame length; the generator side is paced by a valid/ready handshake.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles (D); legal range 1..255.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample  in  16  unsigned waveform sample from generator.
- sample_valid  in  1  sample is valid; may be tied high.
- sample_ready  out  1  block accepts a sample this cycle.
- gain  in  8  amplitude gain; effective factor (gain+1)/256.
- dac_cs_n  out  1  DAC chip select, active low.
- dac_sclk  out  1  DAC serial clock, idle low.
- dac_mosi  out  1  DAC serial data; DAC samples on SCLK rising edge.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.

## Operation
- All outputs are registered.
- FSM states: IDLE, SCALE, SETUP, SHIFT, HOLD.
- **IDLE:**
  - sample_ready=1, cs_n=1, sclk=0, mosi=0.
  - On a clk edge with sample_valid&sample_ready: latch sample and gain, go to SCALE.
- **SCALE (1 cycle):**
  - scaled = (sample × ({1'b0,gain}+1))[23:8]. The product is 25 bits; bits [23:8] are kept, with no rounding and no saturation.
  - gain=255 passes the sample unchanged; gain=0 gives sample>>8.
  - Go to SETUP.
- **SETUP (D cycles):** cs_n=0, sclk=0, mosi=scaled[15].
- **SHIFT:** 16 bit periods, bit index 15 down to 0. Each bit period is:
  - D cycles with sclk=1, then D cycles with sclk=0.
  - mosi changes to the next bit on the sclk 1→0 transition.
  - mosi is held at bit 0 through its low half.
- **HOLD (D cycles):**
  - cs_n=1, sclk=0, mosi=0.
  - frame_done=1 on the first HOLD cycle only.
  - After D cycles, go to IDLE.
- sample_valid and sample/gain changes outside IDLE are ignored. The in-flight frame uses the values latched at accept.
- Internal counters:
  - Divider counter: 8 bits, counts 0..D-1.
  - Bit counter: 4 bits.
  - Half-phase flag.

## Timing
- **Reset values** (asynchronous, while reset=0): state=IDLE, sample_ready=0, cs_n=1, sclk=0, mosi=0, busy=0, frame_done=0, all counters 0.
- **After reset release:** sample_ready=1 from the first clk edge following release.
- **Latency:** accept edge → cs_n low = 2 cycles (SCALE, then SETUP entry).
- **cs_n low time:** D + 32D = 33D cycles.
- **First SCLK rising edge:** D cycles after cs_n falls.
- **Frame period with sample_valid held high:** 34D+2 cycles (IDLE 1 + SCALE 1 + SETUP D + SHIFT 32D + HOLD D). For D=4 this is 138 cycles.
- **busy:** rises on the edge following accept and falls on entry to IDLE.
- **Reset mid-frame:**
  - Outputs immediately take their reset values (cs_n=1 terminates the DAC frame).
  - The frame is discarded and no frame_done is issued.
- **D=1:** SCLK period is 2 clk cycles. The state sequence is otherwise unchanged.
- **Simultaneous events:** sample_valid rising in the same cycle as the HOLD→IDLE transition is not accepted until the IDLE cycle. There is no combinational ready.

## Test plan
- **Basic frame:** D=4, gain=255, sample=0xA5C3, valid pulsed 1 cycle → mosi captured on the 16 sclk rising edges = 1010_0101_1100_0011; cs_n low exactly 132 cycles; one frame_done pulse; busy returns to 0.
- **Gain arithmetic:**
  - sample=0x8000, gain=127 → DAC word 0x4000.
  - sample=0xFFFF, gain=0 → 0x00FF.
  - sample=0xFFFF, gain=255 → 0xFFFF.
- **Back-to-back:** sample_valid tied high with sample incrementing each cycle → accept edges exactly 138 cycles apart (D=4); each word equals the sample present at its accept edge.
- **Ignore while busy:** change sample and gain mid-SHIFT → current frame word unchanged; sample_ready stays 0 until IDLE.
- **Reset mid-shift:** assert reset at bit 7 → cs_n=1, sclk=0, mosi=0 asynchronously; no frame_done; after release, next accepted sample produces a full correct frame.
- **D=1 boundary:** CLK_DIV=1, sample=0x0001 → sclk toggles every cycle; frame period 36 cycles; mosi high only for the last bit.
